pipe_ctrl_unit: RTL and testbench

// - Parametrised successor to the ID-stage main decoder: decodes opcode into the control bundle and registers it as the ID/EX control latch.
// - Adds hazard bubbles, branch flush, and a multi-cycle MUL sequencer that stalls the front end while MUL occupies EX.
// - Sits between IF/ID and the EX-stage ALU control / forwarding logic.

---
 rtl/pipe_ctrl_unit.sv | 196 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control decoder with ID/EX control latch, bubble/flush handling and a MUL stall sequencer.
// Optional feature: define CTRL_ILLEGAL_OP_EN to flag unknown opcodes on illegal_o.
module pipe_ctrl_unit #(
   parameter int ALUOP_W = 2,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [6:0]         Op_i,
   input  logic [2:0]         funct3_i,
   input  logic [6:0]         funct7_i,
   input  logic               NoOp_i,
   input  logic               Flush_i,
   output logic               RegWrite_o,
   output logic               MemtoReg_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               ALUSrc_o,
   output logic               Branch_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               ex_valid_o,
   output logic               Stall_o,
   output logic               illegal_o
);

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BRNCH = 7'b1100011;
   localparam logic [6:0] F7_MUL   = 7'b0000001;
   localparam logic [2:0] F3_MUL   = 3'b000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Result layout: {known, RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]}
   function automatic logic [8:0] decode_f(input logic [6:0] op);
      logic [8:0] r;
      case (op)
         OP_RTYPE: r = 9'b1_1000_0010;
         OP_ITYPE: r = 9'b1_1000_1000;
         OP_LOAD:  r = 9'b1_1110_1000;
         OP_STORE: r = 9'b1_0001_1000;
         OP_BRNCH: r = 9'b1_0000_0101;
         default:  r = 9'b0_0000_0000;
      endcase
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               regwrite_q, regwrite_d;
   logic               memtoreg_q, memtoreg_d;
   logic               memread_q, memread_d;
   logic               memwrite_q, memwrite_d;
   logic               alusrc_q, alusrc_d;
   logic               branch_q, branch_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic               ex_valid_q, ex_valid_d;
   logic [8:0]         dec_s;
   logic               is_mul_s;
`ifdef CTRL_ILLEGAL_OP_EN
   logic               illegal_q, illegal_d;
`endif

   assign dec_s    = decode_f(Op_i);
   assign is_mul_s = (Op_i == OP_RTYPE) && (funct7_i == F7_MUL) && (funct3_i == F3_MUL);

   // Next-state: flush beats the BUSY hold, which beats bubbles, which beat decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      alusrc_d   = alusrc_q;
      branch_d   = branch_q;
      aluop_d    = aluop_q;
      ex_valid_d = ex_valid_q;
`ifdef CTRL_ILLEGAL_OP_EN
      illegal_d  = 1'b0;
`endif
      if (Flush_i) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         alusrc_d   = 1'b0;
         branch_d   = 1'b0;
         aluop_d    = '0;
         ex_valid_d = 1'b0;
      end else if (state_q == ST_BUSY) begin
         // Bundle is held; only the writeback enable changes, on the final MUL cycle.
         if (cnt_q == CNT_W'(1)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            regwrite_d = 1'b1;
         end else begin
            cnt_d      = cnt_q - CNT_W'(1);
         end
      end else if (NoOp_i || !valid_i) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         alusrc_d   = 1'b0;
         branch_d   = 1'b0;
         aluop_d    = '0;
         ex_valid_d = 1'b0;
      end else begin
         regwrite_d = dec_s[7];
         memtoreg_d = dec_s[6];
         memread_d  = dec_s[5];
         memwrite_d = dec_s[4];
         alusrc_d   = dec_s[3];
         branch_d   = dec_s[2];
         aluop_d    = ALUOP_W'(dec_s[1:0]);
         ex_valid_d = 1'b1;
`ifdef CTRL_ILLEGAL_OP_EN
         if (!dec_s[8]) begin
            ex_valid_d = 1'b0;
            illegal_d  = 1'b1;
         end else begin
            illegal_d  = 1'b0;
         end
`endif
         if (is_mul_s && (MUL_LAT > 1)) begin
            state_d    = ST_BUSY;
            cnt_d      = CNT_W'(MUL_LAT - 1);
            regwrite_d = 1'b0;
         end else begin
            state_d    = ST_IDLE;
         end
      end
   end

   // ID/EX control latch and sequencer state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         branch_q   <= 1'b0;
         aluop_q    <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         alusrc_q   <= alusrc_d;
         branch_q   <= branch_d;
         aluop_q    <= aluop_d;
         ex_valid_q <= ex_valid_d;
      end
   end

`ifdef CTRL_ILLEGAL_OP_EN
   // Illegal-opcode pulse, aligned with the bundle it accompanies.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end
   assign illegal_o = illegal_q;
`else
   assign illegal_o = 1'b0;
`endif

   assign RegWrite_o = regwrite_q;
   assign MemtoReg_o = memtoreg_q;
   assign MemRead_o  = memread_q;
   assign MemWrite_o = memwrite_q;
   assign ALUSrc_o   = alusrc_q;
   assign Branch_o   = branch_q;
   assign ALUOp_o    = aluop_q;
   assign ex_valid_o = ex_valid_q;
   assign Stall_o    = (state_q == ST_BUSY);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed and randomized bench for pipe_ctrl_unit against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

   localparam int MUL_LAT = 3;
`ifdef CTRL_ILLEGAL_OP_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       valid_i = 1'b0;
   logic [6:0] Op_i = 7'd0;
   logic [2:0] funct3_i = 3'd0;
   logic [6:0] funct7_i = 7'd0;
   logic       NoOp_i = 1'b0;
   logic       Flush_i = 1'b0;
   logic       RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
   logic [1:0] ALUOp_o;
   logic       ex_valid_o, Stall_o, illegal_o;

   int vectors = 0;
   int miscompares = 0;

   // Model state: expected outputs and remaining BUSY edges of an in-flight MUL.
   logic [7:0] m_bundle;   // {rw,mtr,mr,mw,as,br,aluop[1:0]}
   logic       m_exv, m_ill;
   int         m_left;

   pipe_ctrl_unit #(.ALUOP_W(2), .MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
      .funct3_i(funct3_i), .funct7_i(funct7_i), .NoOp_i(NoOp_i), .Flush_i(Flush_i),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
      .ALUOp_o(ALUOp_o), .ex_valid_o(ex_valid_o), .Stall_o(Stall_o), .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [10:0] obs_f();
      return {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
              ALUOp_o, ex_valid_o, Stall_o, illegal_o};
   endfunction

   function automatic logic [10:0] exp_f();
      return {m_bundle, m_exv, (m_left > 0), m_ill};
   endfunction

   // Returns {known, bundle} straight from the opcode table.
   function automatic logic [8:0] table_f(input logic [6:0] op);
      case (op)
         7'b0110011: return {1'b1, 8'b1000_0010};
         7'b0010011: return {1'b1, 8'b1000_1000};
         7'b0000011: return {1'b1, 8'b1110_1000};
         7'b0100011: return {1'b1, 8'b0001_1000};
         7'b1100011: return {1'b1, 8'b0000_0101};
         default:    return {1'b0, 8'b0000_0000};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_bundle = 8'd0; m_exv = 1'b0; m_ill = 1'b0; m_left = 0;
   endtask

   task automatic model_edge(input logic v, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic nop, input logic fl);
      logic [8:0] t;
      m_ill = 1'b0;
      if (fl) begin
         m_bundle = 8'd0; m_exv = 1'b0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_bundle[7] = 1'b1;
      end else if (nop || !v) begin
         m_bundle = 8'd0; m_exv = 1'b0;
      end else begin
         t = table_f(op);
         m_bundle = t[7:0];
         m_exv = 1'b1;
         if (!t[8] && ILL_EN) begin
            m_exv = 1'b0; m_ill = 1'b1;
         end
         if (op == 7'b0110011 && f7 == 7'b0000001 && f3 == 3'b000 && MUL_LAT > 1) begin
            m_bundle[7] = 1'b0;
            m_left = MUL_LAT - 1;
         end
      end
   endtask

   task automatic step(input string tag, input logic v, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic nop, input logic fl);
      valid_i = v; Op_i = op; funct3_i = f3; funct7_i = f7; NoOp_i = nop; Flush_i = fl;
      model_edge(v, op, f3, f7, nop, fl);
      @(posedge clk_i);
      #1;
      chk(tag, obs_f(), exp_f());
   endtask

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                          SW = 7'b0100011, BEQ = 7'b1100011;

   initial begin
      model_reset();
      #12;
      chk("reset", obs_f(), exp_f());
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Table sequence, also checked against literal bundles.
      step("lw",   1'b1, LW,  3'd2, 7'd0, 1'b0, 1'b0); chk("lw_c",   obs_f(), 11'b11101000100);
      step("sw",   1'b1, SW,  3'd2, 7'd0, 1'b0, 1'b0); chk("sw_c",   obs_f(), 11'b00011000100);
      step("beq",  1'b1, BEQ, 3'd0, 7'd0, 1'b0, 1'b0); chk("beq_c",  obs_f(), 11'b00000101100);
      step("addi", 1'b1, I,   3'd0, 7'd0, 1'b0, 1'b0); chk("addi_c", obs_f(), 11'b10001000100);
      step("add",  1'b1, R,   3'd0, 7'd0, 1'b0, 1'b0); chk("add_c",  obs_f(), 11'b10000010100);

      // MUL: two stall cycles, writeback only in the third, add captured after.
      step("mul0", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0); chk("mul0_c", obs_f(), 11'b00000010110);
      step("mul1", 1'b1, I, 3'd0, 7'd0, 1'b1, 1'b0); chk("mul1_c", obs_f(), 11'b00000010110);
      step("mul2", 1'b1, I, 3'd0, 7'd0, 1'b0, 1'b0); chk("mul2_c", obs_f(), 11'b10000010100);
      step("mul_next_add", 1'b1, R, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("mul_next_add_c", obs_f(), 11'b10000010100);

      // Back-to-back MULs.
      step("b2b0", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("b2b1", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("b2b2", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("b2b3", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0); chk("b2b3_c", obs_f(), 11'b00000010110);
      step("b2b4", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0);
      step("b2b5", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0); chk("b2b5_c", obs_f(), 11'b10000010100);

      // Load-use bubble then capture.
      step("noop_lw", 1'b1, LW, 3'd2, 7'd0, 1'b1, 1'b0); chk("noop_lw_c", obs_f(), 11'd0);
      step("lw_after", 1'b1, LW, 3'd2, 7'd0, 1'b0, 1'b0);

      // Flush in first BUSY cycle kills the MUL.
      step("fl_mul", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("fl_kill", 1'b1, R, 3'd0, 7'd0, 1'b0, 1'b1); chk("fl_kill_c", obs_f(), 11'd0);
      step("fl_post0", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0);
      step("fl_post1", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0);

      // Flush on the final BUSY cycle: writeback suppressed.
      step("fl2_mul", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("fl2_b1",  1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0);
      step("fl2_kill", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b1); chk("fl2_kill_c", obs_f(), 11'd0);

      // Unknown opcode.
      step("illegal", 1'b1, 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
      if (ILL_EN) chk("illegal_c", obs_f(), 11'b00000000001);
      else        chk("illegal_c", obs_f(), 11'b00000000100);

      // Asynchronous reset in the middle of a MUL.
      step("rst_mul0", 1'b1, R, 3'd0, 7'd1, 1'b0, 1'b0);
      step("rst_mul1", 1'b0, R, 3'd0, 7'd0, 1'b0, 1'b0);
      #2 rst_i = 1'b0;
      model_reset();
      #1 chk("rst_mid_busy", obs_f(), 11'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [6:0] op, f7;
         logic [2:0] f3;
         f3 = 3'($urandom_range(0, 7));
         f7 = 7'($urandom_range(0, 127));
         case ($urandom_range(0, 7))
            0: op = R;
            1: begin op = R; f7 = 7'b0000001; f3 = 3'b000; end
            2: op = I;
            3: op = LW;
            4: op = SW;
            5: op = BEQ;
            6: op = 7'b1111111;
            default: op = 7'($urandom_range(0, 127));
         endcase
         step("rand", ($urandom_range(0, 99) < 85), op, f3, f7,
              ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
